// File: rtl/control_sequencer_if.sv
// Control strobe bundle between the hardwired sequencer and the datapath.
// Master drives strobes and consumes Run/IR; slave is the datapath side.
interface control_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5
);
    logic                Run;
    logic [31:0]         IR;
    logic                PCout;
    logic                Zlowout;
    logic                ZHighout;
    logic                MDRout;
    logic                MARin;
    logic                PCin;
    logic                MDRin;
    logic                IRin;
    logic                Yin;
    logic                Zin;
    logic                LOin;
    logic                HIin;
    logic                IncPC;
    logic                Read;
    logic [NUM_REGS-1:0] Rin;
    logic [NUM_REGS-1:0] Rout;
    logic [OPW-1:0]      operation;
    logic                running;
    logic                halted;
    logic                illegal;

    modport master (
        input  Run, IR,
        output PCout, Zlowout, ZHighout, MDRout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin,
        output IncPC, Read, Rin, Rout, operation,
        output running, halted, illegal
    );

    modport slave (
        output Run, IR,
        input  PCout, Zlowout, ZHighout, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin,
        input  IncPC, Read, Rin, Rout, operation,
        input  running, halted, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: T0..T6 state machine decoding IR
// into datapath bus selects, load enables and ALU operation codes.
module control_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5
) (
    input logic                  Clock,
    input logic                  Clear,
    control_sequencer_if.master  ctl
);
    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    state_t state;
    state_t state_nx;
    state_t boundary;
    logic   ill_q;

    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       is_alu;
    logic       is_md;
    logic       is_nop;
    logic       is_hlt;
    logic       is_ill;
    logic       unused_ir;

    logic [NUM_REGS-1:0] one;

    assign opcode    = ctl.IR[31:27];
    assign ra        = ctl.IR[26:23];
    assign rb        = ctl.IR[22:19];
    assign rc        = ctl.IR[18:15];
    assign unused_ir = ^ctl.IR[14:0];

    assign is_alu = (opcode <= 5'h0B);
    assign is_md  = (opcode == 5'h0F) || (opcode == 5'h10);
    assign is_nop = (opcode == 5'h1A);
    assign is_hlt = (opcode == 5'h1B);
    assign is_ill = !(is_alu || is_md || is_nop || is_hlt);

    assign one      = NUM_REGS'(1);
    // Run only matters at instruction boundaries
    assign boundary = ctl.Run ? T0 : IDLE;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state <= IDLE;
            ill_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == T3 && is_ill)
                ill_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx      = state;
        ctl.PCout     = 1'b0;
        ctl.Zlowout   = 1'b0;
        ctl.ZHighout  = 1'b0;
        ctl.MDRout    = 1'b0;
        ctl.MARin     = 1'b0;
        ctl.PCin      = 1'b0;
        ctl.MDRin     = 1'b0;
        ctl.IRin      = 1'b0;
        ctl.Yin       = 1'b0;
        ctl.Zin       = 1'b0;
        ctl.LOin      = 1'b0;
        ctl.HIin      = 1'b0;
        ctl.IncPC     = 1'b0;
        ctl.Read      = 1'b0;
        ctl.Rin       = '0;
        ctl.Rout      = '0;
        ctl.operation = '0;
        ctl.running   = 1'b0;
        ctl.halted    = 1'b0;
        ctl.illegal   = ill_q;
        unique case (state)
            IDLE: begin
                if (ctl.Run)
                    state_nx = T0;
            end
            T0: begin
                ctl.running = 1'b1;
                ctl.PCout   = 1'b1;
                ctl.MARin   = 1'b1;
                ctl.IncPC   = 1'b1;
                ctl.Zin     = 1'b1;
                state_nx    = T1;
            end
            T1: begin
                ctl.running = 1'b1;
                ctl.Zlowout = 1'b1;
                ctl.PCin    = 1'b1;
                ctl.Read    = 1'b1;
                ctl.MDRin   = 1'b1;
                state_nx    = T2;
            end
            T2: begin
                ctl.running = 1'b1;
                ctl.MDRout  = 1'b1;
                ctl.IRin    = 1'b1;
                state_nx    = T3;
            end
            T3: begin
                ctl.running = 1'b1;
                unique case (1'b1)
                    is_alu: begin
                        ctl.Rout = one << rb;
                        ctl.Yin  = 1'b1;
                        state_nx = T4;
                    end
                    is_md: begin
                        ctl.Rout = one << ra;
                        ctl.Yin  = 1'b1;
                        state_nx = T4;
                    end
                    is_hlt: begin
                        state_nx = HALT;
                    end
                    default: begin
                        ctl.illegal = ill_q | is_ill;
                        state_nx    = boundary;
                    end
                endcase
            end
            T4: begin
                ctl.running   = 1'b1;
                ctl.Rout      = one << (is_md ? rb : rc);
                ctl.Zin       = 1'b1;
                ctl.operation = OPW'(opcode);
                state_nx      = T5;
            end
            T5: begin
                ctl.running = 1'b1;
                ctl.Zlowout = 1'b1;
                if (is_md) begin
                    ctl.LOin = 1'b1;
                    state_nx = T6;
                end else begin
                    ctl.Rin  = one << ra;
                    state_nx = boundary;
                end
            end
            T6: begin
                ctl.running  = 1'b1;
                ctl.ZHighout = 1'b1;
                ctl.HIin     = 1'b1;
                state_nx     = boundary;
            end
            HALT: begin
                ctl.halted = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer against a per-instruction
// expected-strobe-sequence model built from the instruction classes.
module tb_control_sequencer;
    localparam int NR = 16;
    localparam int OW = 5;

    localparam logic [13:0] B_PCO  = 14'd1 << 13;
    localparam logic [13:0] B_ZLO  = 14'd1 << 12;
    localparam logic [13:0] B_ZHI  = 14'd1 << 11;
    localparam logic [13:0] B_MDRO = 14'd1 << 10;
    localparam logic [13:0] B_MAR  = 14'd1 << 9;
    localparam logic [13:0] B_PCI  = 14'd1 << 8;
    localparam logic [13:0] B_MDRI = 14'd1 << 7;
    localparam logic [13:0] B_IRI  = 14'd1 << 6;
    localparam logic [13:0] B_YI   = 14'd1 << 5;
    localparam logic [13:0] B_ZI   = 14'd1 << 4;
    localparam logic [13:0] B_LO   = 14'd1 << 3;
    localparam logic [13:0] B_HI   = 14'd1 << 2;
    localparam logic [13:0] B_INC  = 14'd1 << 1;
    localparam logic [13:0] B_RD   = 14'd1 << 0;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic ill = 1'b0;

    always #5 clk = ~clk;

    control_sequencer_if #(.NUM_REGS(NR), .OPW(OW)) bus ();

    control_sequencer #(.NUM_REGS(NR), .OPW(OW)) dut (
        .Clock (clk),
        .Clear (clr),
        .ctl   (bus.master)
    );

    function automatic logic [53:0] obs();
        return {bus.PCout, bus.Zlowout, bus.ZHighout, bus.MDRout,
                bus.MARin, bus.PCin, bus.MDRin, bus.IRin,
                bus.Yin, bus.Zin, bus.LOin, bus.HIin,
                bus.IncPC, bus.Read, bus.Rin, bus.Rout,
                bus.operation, bus.running, bus.halted, bus.illegal};
    endfunction

    function automatic logic [53:0] w(input logic [13:0] s,
                                      input logic [15:0] ri,
                                      input logic [15:0] ro,
                                      input logic [4:0]  op,
                                      input logic rn,
                                      input logic hl,
                                      input logic il);
        return {s, ri, ro, op, rn, hl, il};
    endfunction

    task automatic check(input string tag,
                         input logic [53:0] got,
                         input logic [53:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // mode: 0 random Run, 1 clear during T4, 2 drop Run at T4, 3 Run held
    task automatic exec(input logic [31:0] instr, input int mode);
        logic [53:0] q[$];
        logic [4:0]  opc;
        logic [15:0] ra1, rb1, rc1;
        bit          alu, md, hlt, bad;
        logic        ill_n;
        opc  = instr[31:27];
        ra1  = 16'd1 << instr[26:23];
        rb1  = 16'd1 << instr[22:19];
        rc1  = 16'd1 << instr[18:15];
        alu  = (opc <= 5'd11);
        md   = (opc == 5'd15) || (opc == 5'd16);
        hlt  = (opc == 5'd27);
        bad  = !(alu || md || hlt || opc == 5'd26);
        ill_n = ill | bad;
        q.push_back(w(B_PCO | B_MAR | B_INC | B_ZI, 0, 0, 0, 1, 0, ill));
        q.push_back(w(B_ZLO | B_PCI | B_RD | B_MDRI, 0, 0, 0, 1, 0, ill));
        q.push_back(w(B_MDRO | B_IRI, 0, 0, 0, 1, 0, ill));
        if (alu) begin
            q.push_back(w(B_YI, 0, rb1, 0, 1, 0, ill));
            q.push_back(w(B_ZI, 0, rc1, opc, 1, 0, ill));
            q.push_back(w(B_ZLO, ra1, 0, 0, 1, 0, ill));
        end else if (md) begin
            q.push_back(w(B_YI, 0, ra1, 0, 1, 0, ill));
            q.push_back(w(B_ZI, 0, rb1, opc, 1, 0, ill));
            q.push_back(w(B_ZLO | B_LO, 0, 0, 0, 1, 0, ill));
            q.push_back(w(B_ZHI | B_HI, 0, 0, 0, 1, 0, ill));
        end else begin
            q.push_back(w(0, 0, 0, 0, 1, 0, ill_n));
        end
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            check($sformatf("op%0h_t%0d", opc, i), obs(), q[i]);
            if (i == 0)
                bus.IR = instr;
            if (mode == 1 && i == 4) begin
                #2 clr = 1'b0;
                #1 check("rst_async", obs(), 54'd0);
                bus.Run = 1'b1;
                @(negedge clk);
                check("rst_hold", obs(), 54'd0);
                clr = 1'b1;
                ill = 1'b0;
                return;
            end
            case (mode)
                2:       bus.Run = (i < 4);
                3:       bus.Run = 1'b1;
                default: bus.Run = (i == q.size() - 1) ?
                                   ($urandom_range(3) != 0) : 1'($urandom);
            endcase
        end
        ill = ill_n;
        if (hlt) begin
            bus.Run = 1'b1;
            repeat (20) begin
                @(negedge clk);
                check("halt", obs(), w(0, 0, 0, 0, 0, 1, ill));
            end
            #2 clr = 1'b0;
            #1 check("halt_clr", obs(), 54'd0);
            @(negedge clk);
            check("halt_idle", obs(), 54'd0);
            clr = 1'b1;
            ill = 1'b0;
            return;
        end
        while (!bus.Run) begin
            @(negedge clk);
            check("idle", obs(), w(0, 0, 0, 0, 0, 0, ill));
            bus.Run = (mode == 2) ? 1'b1 : 1'($urandom);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] opc;
        int k;
        k = $urandom_range(19);
        if (k < 10)      opc = 5'($urandom_range(11));
        else if (k < 14) opc = (k[0]) ? 5'h0F : 5'h10;
        else if (k < 16) opc = 5'h1A;
        else if (k < 19) opc = 5'($urandom_range(17, 25));
        else             opc = 5'h1B;
        if (k >= 16 && k < 19 && $urandom_range(1) == 1)
            opc = 5'($urandom_range(12, 14));
        return {opc, 4'($urandom), 4'($urandom), 4'($urandom),
                15'($urandom)};
    endfunction

    initial begin
        logic [31:0] ins;
        bus.Run = 1'b1;
        bus.IR  = 32'h0;
        #1 clr = 1'b0;
        @(negedge clk);
        check("reset", obs(), 54'd0);
        clr = 1'b1;
        exec(32'h2A2B8000, 3);
        exec(32'h79180000, 3);
        exec(32'hF8000000, 3);
        exec(32'hD0000000, 3);
        exec(32'h2A2B8000, 2);
        exec(32'h2A2B8000, 1);
        exec(32'h81000000, 0);
        for (int n = 0; n < 120; n++) begin
            ins = rand_instr();
            if ((ins[31:27] <= 5'd11 || ins[31:27] == 5'h0F ||
                 ins[31:27] == 5'h10) && $urandom_range(11) == 0)
                exec(ins, 1);
            else
                exec(ins, 0);
        end
        exec(32'hD8000000, 3);
        exec(32'h40880000, 3);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the CPU datapath's control strobes. It is the initiator the datapath currently receives from directed stimulus.
- Steps an instruction-fetch / execute state machine (T0..T6) and decodes the datapath's IR output.
- Sits beside the datapath and owns every register in/out select, ALU operation code, memory read strobe and PC/IR/Y/Z/HI/LO load.
- Supports 3-register ALU ops, mul/div to HI/LO, nop and halt.

Parameters:
- NUM_REGS, 16, general-purpose register count; width of the Rin/Rout one-hot buses.
- OPW, 5, opcode / ALU operation width.

Ports:
- Clock  input  1  system clock, rising-edge active.
- Clear  input  1  asynchronous, active-low reset.
- Run  input  1  level; 1 lets the sequencer leave T0 / IDLE.
- IR  input  32  datapath IR contents. opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
- PCout, Zlowout, ZHighout, MDRout  output  1 each  bus drive selects.
- MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin  output  1 each  register load enables.
- IncPC, Read  output  1 each  PC-increment request to ALU; memory read strobe.
- Rin  output  NUM_REGS  one-hot GPR load enable.
- Rout  output  NUM_REGS  one-hot GPR bus drive.
- operation  output  OPW  ALU operation code.
- running  output  1  high in any T state.
- halted  output  1  high in HALT.
- illegal  output  1  sticky; set on an undefined opcode.

Behaviour:
- State register is async-cleared. States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- All control outputs are decoded from the current state plus IR. They are never registered a second time.
- Any output not listed for a state is 0.
- Reset (Clear=0, async, at any time including mid-instruction):
  - state = IDLE; every output = 0, including illegal and operation = 0.
  - The in-flight instruction is abandoned; no partial writes are completed.
- IDLE: on a rising edge with Run=1, go to T0; otherwise stay.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - IR is valid from T3 onward.
- Decode (in T3, from IR[31:27]):
  - 0x00-0x0B: ALU3 class.
  - 0x0F, 0x10: MULDIV class (0x0F mul, 0x10 div).
  - 0x1A: NOP.
  - 0x1B: HALT.
  - Any other value: ILLEGAL.
- ALU3 class:
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], Zin, operation = opcode.
  - T5: Zlowout, Rin[Ra].
  - Then T0 if Run=1, else IDLE.
- MULDIV class:
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], Zin, operation = opcode.
  - T5: Zlowout, LOin.
  - T6: ZHighout, HIin.
  - Then T0 / IDLE per Run.
- NOP: T3 asserts nothing; next state is T0 / IDLE per Run.
- HALT opcode: T3 → HALT. HALT is absorbing until Clear; halted = 1 and all strobes are 0.
- ILLEGAL: T3 sets illegal (sticky until Clear), asserts nothing, then goes to T0 / IDLE per Run.
- Run is sampled only at instruction boundaries (end of T5/T6/T3-nop). Deasserting Run mid-instruction never truncates the instruction.
- operation = 0 in every state except T4.
- Rin/Rout are one-hot or all-zero; at most one bit set. Register index 0 is a normal register.
- Bus exclusivity: in every state at most one of PCout, Zlowout, ZHighout, MDRout and the Rout bits is 1.
- Latency:
  - Instruction cycles, T0 entry to next T0 entry: ALU3 6, MULDIV 7, NOP/illegal 4.
  - IDLE→T0 takes 1 clock after Run is seen.
- running = 1 in T0..T6; 0 in IDLE and HALT.

Test Plan:
- ALU3 SHR-form: Clear pulse, Run=1, IR=0x2A2B8000 (op 5, Ra 4, Rb 5, Rc 7) → expect:
  - T3: Rout=0x0020, Yin.
  - T4: Rout=0x0080, Zin, operation=5.
  - T5: Zlowout, Rin=0x0010.
  - Next edge in T0.
- Fetch: after reset release with Run=1 → exactly one cycle each of:
  - {PCout, MARin, IncPC, Zin}
  - {Zlowout, PCin, Read, MDRin}
  - {MDRout, IRin}
  - All other strobes 0.
- MUL: IR=0x79180000 (op 0x0F, Ra 2, Rb 3) →
  - T3: Rout=0x0004, Yin.
  - T4: Rout=0x0008, operation=0x0F.
  - T5: Zlowout, LOin.
  - T6: ZHighout, HIin.
  - 7 cycles T0→T0.
- HALT: IR=0xD8000000 → HALT after T3; halted=1 and running=0 for 20 cycles with Run=1; Clear low returns to IDLE.
- Illegal: IR=0xF8000000 → illegal=1 from T3 onward and stays 1 through the next instruction; Rin=0 throughout; sequencer returns to T0.
- Reset mid-op, plus Run drop:
  - Assert Clear=0 during T4 of an ALU3 op → outputs 0 immediately, with no Rin pulse.
  - Separately, drop Run in T4 → T5 completes (Rin pulses) and then IDLE.
